// File: rtl/auto_codebreaker.sv
// Automatic Mastermind player: plays one game per go request, choosing each guess as
// the first candidate consistent with every graded guess so far.
module auto_codebreaker #(
  parameter int HIST_DEPTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic [2:0]  feedback0,
  input  logic [2:0]  feedback1,
  input  logic [2:0]  feedback2,
  input  logic [2:0]  feedback3,
  input  logic        won,
  input  logic        lost,
  output logic        start_game,
  output logic        grade_it,
  output logic [11:0] guess,
  output logic        busy,
  output logic        solved,
  output logic        failed,
  output logic [3:0]  guesses_used
);

  localparam int IW = $clog2(HIST_DEPTH + 1);
  localparam logic [IW-1:0] DEPTH      = IW'(HIST_DEPTH);
  localparam logic [IW-1:0] DEPTH_LAST = IW'(HIST_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEARCH, S_PRESENT, S_HOLD, S_SAMPLE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] hcount_q, hcount_d;
  logic [IW-1:0] hidx_q, hidx_d;
  logic [11:0]   cand_q, cand_d;
  logic [11:0]   guess_q, guess_d;
  logic          solved_q, solved_d;
  logic          failed_q, failed_d;
  logic [3:0]    used_q, used_d;

  logic [17:0]   hist_q [HIST_DEPTH];
  logic          hist_we;
  logic [17:0]   hist_rd;
  logic [5:0]    cand_grade;

  logic [2:0]    fb [4];
  logic [3:0]    fb_red, fb_white;
  logic [2:0]    s_red, s_white;

  // Grades guess g against pattern p: {red, white}, reds claimed before whites.
  function automatic logic [5:0] grade(input logic [11:0] g, input logic [11:0] p);
    logic [2:0] gp [4];
    logic [2:0] pp [4];
    logic [3:0] pused, gred;
    logic [2:0] red, white;
    logic       found;
    red   = 3'd0;
    white = 3'd0;
    pused = 4'd0;
    gred  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      gp[i] = g[11-3*i -: 3];
      pp[i] = p[11-3*i -: 3];
    end
    for (int i = 0; i < 4; i++) begin
      if (gp[i] == pp[i]) begin
        red      = red + 3'd1;
        pused[i] = 1'b1;
        gred[i]  = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (!gred[i] && !found && !pused[j] && gp[i] == pp[j]) begin
          found    = 1'b1;
          pused[j] = 1'b1;
          white    = white + 3'd1;
        end
      end
    end
    return {red, white};
  endfunction

  assign fb[0] = feedback0;
  assign fb[1] = feedback1;
  assign fb[2] = feedback2;
  assign fb[3] = feedback3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fb
      assign fb_red[gi]   = (fb[gi] == 3'b111);
      assign fb_white[gi] = (fb[gi] == 3'b001);
    end
  endgenerate

  assign s_red   = 3'(fb_red[0])   + 3'(fb_red[1])   + 3'(fb_red[2])   + 3'(fb_red[3]);
  assign s_white = 3'(fb_white[0]) + 3'(fb_white[1]) + 3'(fb_white[2]) + 3'(fb_white[3]);

  // History guess drives the guess operand, the candidate drives the pattern operand.
  assign hist_rd    = hist_q[hidx_q];
  assign cand_grade = grade(hist_rd[17:6], cand_q);

  always_ff @(posedge clock) begin
    if (hist_we) begin
      hist_q[hcount_q] <= {guess_q, s_red, s_white};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      hcount_q <= '0;
      hidx_q   <= '0;
      cand_q   <= 12'd0;
      guess_q  <= 12'd0;
      solved_q <= 1'b0;
      failed_q <= 1'b0;
      used_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      hidx_q   <= hidx_d;
      cand_q   <= cand_d;
      guess_q  <= guess_d;
      solved_q <= solved_d;
      failed_q <= failed_d;
      used_q   <= used_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hcount_d   = hcount_q;
    hidx_d     = hidx_q;
    cand_d     = cand_q;
    guess_d    = guess_q;
    solved_d   = solved_q;
    failed_d   = failed_q;
    used_d     = used_q;
    hist_we    = 1'b0;
    start_game = 1'b0;
    grade_it   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) state_d = S_START;
      end
      S_START: begin
        start_game = 1'b1;
        hcount_d   = '0;
        hidx_d     = '0;
        cand_d     = 12'd0;
        used_d     = 4'd0;
        solved_d   = 1'b0;
        failed_d   = 1'b0;
        state_d    = S_SEARCH;
      end
      S_SEARCH: begin
        if (hidx_q == hcount_q) begin
          guess_d = cand_q;
          state_d = S_PRESENT;
        end else if (cand_grade == hist_rd[5:0]) begin
          hidx_d = hidx_q + 1'b1;
        end else if (cand_q == 12'hFFF) begin
          failed_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cand_d = cand_q + 12'd1;
          hidx_d = '0;
        end
      end
      S_PRESENT: begin
        grade_it = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        hist_we  = (hcount_q != DEPTH);
        hcount_d = (hcount_q == DEPTH) ? hcount_q : hcount_q + 1'b1;
        used_d   = used_q + 4'd1;
        // Outcome priority: win, loss, full history, exhausted candidates.
        if (won) begin
          solved_d = 1'b1;
          state_d  = S_DONE;
        end else if (lost || hcount_q >= DEPTH_LAST || cand_q == 12'hFFF) begin
          failed_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cand_d  = cand_q + 12'd1;
          hidx_d  = '0;
          state_d = S_SEARCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign guess        = guess_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign solved       = solved_q;
  assign failed       = failed_q;
  assign guesses_used = used_q;

endmodule

// File: tb/tb_auto_codebreaker.sv
// Directed bench for auto_codebreaker with a behavioural game that grades against a
// secret pattern and drives feedback only during the DUT's sampling cycle.
module tb_auto_codebreaker;

  logic        clock = 1'b0;
  logic        reset;
  logic        go;
  logic [2:0]  fb_q [4];
  logic        won_q, lost_q;
  logic        start_game, grade_it, busy, solved, failed;
  logic [11:0] guess;
  logic [3:0]  guesses_used;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_grade  = 0;
  int          n_start  = 0;

  logic [11:0] pat;
  int          mode;
  int          lost_at;
  logic [11:0] glog [16];

  logic        g1_q;
  logic [11:0] gq_q;
  int          gcount;

  auto_codebreaker #(.HIST_DEPTH(10)) dut (
    .clock(clock), .reset(reset), .go(go),
    .feedback0(fb_q[0]), .feedback1(fb_q[1]), .feedback2(fb_q[2]), .feedback3(fb_q[3]),
    .won(won_q), .lost(lost_q),
    .start_game(start_game), .grade_it(grade_it), .guess(guess),
    .busy(busy), .solved(solved), .failed(failed), .guesses_used(guesses_used)
  );

  always #5 clock = ~clock;

  // Reference grading by colour counts; returns the k-th feedback peg (reds first).
  function automatic logic [2:0] fb_peg(input logic [11:0] g, input logic [11:0] p, input int k);
    int cg [8];
    int cp [8];
    int r, tot, w;
    logic [2:0] a, b;
    r = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      cg[c] = 0;
      cp[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      a = g[11-3*i -: 3];
      b = p[11-3*i -: 3];
      if (a == b) r++;
      cg[a]++;
      cp[b]++;
    end
    for (int c = 0; c < 8; c++) tot += (cg[c] < cp[c]) ? cg[c] : cp[c];
    w = tot - r;
    if (k < r) return 3'b111;
    if (k < r + w) return 3'b001;
    return 3'b000;
  endfunction

  // Game side: feedback is valid only in the cycle two after grade_it, garbage otherwise.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      g1_q   <= 1'b0;
      gq_q   <= 12'd0;
      gcount <= 0;
      won_q  <= 1'b0;
      lost_q <= 1'b0;
      for (int k = 0; k < 4; k++) fb_q[k] <= 3'b111;
    end else begin
      g1_q <= grade_it;
      if (grade_it) begin
        gq_q   <= guess;
        gcount <= gcount + 1;
      end else if (start_game) begin
        gcount <= 0;
      end
      if (g1_q) begin
        for (int k = 0; k < 4; k++) fb_q[k] <= (mode == 1) ? 3'b111 : fb_peg(gq_q, pat, k);
        won_q  <= (mode == 1) || (gq_q == pat);
        lost_q <= (lost_at != 0) && (gcount == lost_at);
      end else begin
        for (int k = 0; k < 4; k++) fb_q[k] <= 3'b111;
        won_q  <= 1'b0;
        lost_q <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (grade_it) n_grade++;
    if (start_game) n_start++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grade(output logic [11:0] g, output bit ok);
    ok = 1'b0;
    g  = 12'd0;
    for (int c = 0; c < 30000; c++) begin
      tick();
      if (grade_it) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("grade_timeout", 32'd0, 32'd1);
      return;
    end
    g = guess;
    $display("grade request: guess=%03h used=%0d", g, guesses_used);
    tick();
    chk("grade_it_width", grade_it, 1'b0);
    chk("guess_hold", guess, g);
    tick();
    chk("guess_sample", guess, g);
  endtask

  task automatic launch();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("start_pulse", start_game, 1'b1);
    chk("busy_start", busy, 1'b1);
    tick();
    chk("start_width", start_game, 1'b0);
    chk("solved_clr", solved, 1'b0);
    chk("failed_clr", failed, 1'b0);
    chk("used_clr", guesses_used, 4'd0);
  endtask

  task automatic play(output int ng);
    logic [11:0] g;
    bit ok;
    ng = 0;
    for (int k = 0; k < 12; k++) begin
      wait_grade(g, ok);
      if (!ok) break;
      glog[ng] = g;
      ng++;
      tick();
      if (!busy) break;
    end
  endtask

  initial begin
    int ng, g0, s0;
    logic [11:0] g;
    bit ok;
    go = 1'b0;
    pat = 12'h515;
    mode = 0;
    lost_at = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_start_game", start_game, 1'b0);
    chk("rst_grade_it", grade_it, 1'b0);
    chk("rst_guess", guess, 12'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_solved", solved, 1'b0);
    chk("rst_failed", failed, 1'b0);
    chk("rst_used", guesses_used, 4'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Game 1: real game against 2-4-2-5, solved on the sixth guess.
    g0 = n_grade;
    s0 = n_start;
    launch();
    play(ng);
    chk("g1_first_guess", glog[0], 12'h000);
    chk("g1_second_guess", glog[1], 12'h249);
    chk("g1_third_guess", glog[2], 12'h492);
    chk("g1_solved", solved, 1'b1);
    chk("g1_failed", failed, 1'b0);
    chk("g1_used", guesses_used, 4'd6);
    chk("g1_guess_final", guess, 12'h515);
    chk("g1_busy", busy, 1'b0);
    chk("g1_grades", n_grade - g0, 6);
    chk("g1_starts", n_start - s0, 1);
    $display("game1: used=%0d solved=%0b guess=%03h", guesses_used, solved, guess);
    for (int i = 0; i < 5; i++) tick();
    chk("g1_hold_solved", solved, 1'b1);
    chk("g1_hold_used", guesses_used, 4'd6);

    // Game 2: stub wins on the very first grade.
    mode = 1;
    g0 = n_grade;
    launch();
    play(ng);
    for (int i = 0; i < 5; i++) tick();
    chk("g2_solved", solved, 1'b1);
    chk("g2_used", guesses_used, 4'd1);
    chk("g2_busy", busy, 1'b0);
    chk("g2_grades", n_grade - g0, 1);
    $display("game2: used=%0d solved=%0b", guesses_used, solved);

    // Game 3: pattern 7-7-7-6 takes more than ten guesses; game reports lost on grade 10.
    mode = 0;
    pat = 12'hFFE;
    lost_at = 10;
    g0 = n_grade;
    launch();
    play(ng);
    chk("g3_seventh_guess", glog[6], 12'hDB6);
    chk("g3_failed", failed, 1'b1);
    chk("g3_solved", solved, 1'b0);
    chk("g3_used", guesses_used, 4'd10);
    chk("g3_busy", busy, 1'b0);
    chk("g3_guess_final", guess, 12'hFF7);
    chk("g3_grades", n_grade - g0, 10);
    $display("game3: used=%0d failed=%0b guess=%03h", guesses_used, failed, guess);

    // Game 4: go ignored during SEARCH, then reset abandons the game.
    pat = 12'h515;
    lost_at = 0;
    launch();
    wait_grade(g, ok);
    tick();
    wait_grade(g, ok);
    tick();
    tick();
    tick();
    s0 = n_start;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("g4_go_ignored", start_game, 1'b0);
    chk("g4_busy", busy, 1'b1);
    chk("g4_guess", guess, 12'h249);
    chk("g4_used", guesses_used, 4'd2);
    #2 reset = 1'b0;
    #1;
    chk("g4_rst_start_game", start_game, 1'b0);
    chk("g4_rst_grade_it", grade_it, 1'b0);
    chk("g4_rst_guess", guess, 12'd0);
    chk("g4_rst_busy", busy, 1'b0);
    chk("g4_rst_solved", solved, 1'b0);
    chk("g4_rst_failed", failed, 1'b0);
    chk("g4_rst_used", guesses_used, 4'd0);
    g0 = n_grade;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("g4_no_grade", n_grade - g0, 0);
    chk("g4_no_start", n_start - s0, 0);
    chk("g4_idle_busy", busy, 1'b0);
    $display("game4: reset mid-search, busy=%0b guess=%03h", busy, guess);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
